// File: rtl/pad_input_pkg.sv
// Shared types and constants for the pulled-up pad input debouncer family.
package pad_input_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_t;

  // Stable cycles needed before a change is accepted (5 ms at 50 MHz).
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

endpackage

// File: rtl/pad_sync.sv
// Multi-flop synchroniser for an asynchronous pad level; reset loads the pad's idle value.
module pad_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pad_input_debouncer.sv
// Synchronises and debounces a raw pad, producing a clean level plus press/release pulses.
module pad_input_debouncer
  import pad_input_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_i,
  output logic level_o,
  output logic pressed_o,
  output logic released_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  deb_state_t       state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             sync_q;
  logic             raw_act;
  logic             level_d, pressed_d, released_d, busy_d;

  // The idle pad value equals ACTIVE_LOW, so reset never looks like a press.
  pad_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pad_i),
    .q     (sync_q)
  );

  assign raw_act = sync_q ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RELEASED;
      cnt        <= '0;
      level_o    <= 1'b0;
      pressed_o  <= 1'b0;
      released_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      level_o    <= level_d;
      pressed_o  <= pressed_d;
      released_o <= released_d;
      busy_o     <= busy_d;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      RELEASED: begin
        if (raw_act) begin
          next_state = PRESS_WAIT;
          next_cnt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!raw_act)             next_state = RELEASED;
        else if (cnt == CNT_LAST) next_state = PRESSED;
        else                      next_cnt   = cnt + 1'b1;
      end
      PRESSED: begin
        if (!raw_act) begin
          next_state = RELEASE_WAIT;
          next_cnt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (raw_act)              next_state = PRESSED;
        else if (cnt == CNT_LAST) next_state = RELEASED;
        else                      next_cnt   = cnt + 1'b1;
      end
      default: begin
        next_state = RELEASED;
        next_cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with it once registered.
  always_comb begin
    level_d    = (next_state == PRESSED) || (next_state == RELEASE_WAIT);
    busy_d     = (next_state == PRESS_WAIT) || (next_state == RELEASE_WAIT);
    pressed_d  = (state == PRESS_WAIT) && (next_state == PRESSED);
    released_d = (state == RELEASE_WAIT) && (next_state == RELEASED);
  end

endmodule
